// File: rtl/oled_spi_ctrl.sv
// Power sequencer and write-only SPI byte transmitter for the SSD1306 OLED.
// Define OLED_SPI_CTRL_INIT_ROM_EN to send the built-in init command sequence after power-up.
module oled_spi_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int T_VDD_CYC  = 1000,
  parameter int T_RST_CYC  = 100,
  parameter int T_VBAT_CYC = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       shutdown_i,
  input  logic [7:0] data_i,
  input  logic       dc_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       pwr_on_o,
  output logic       oled_vdd_n_o,
  output logic       oled_vbat_n_o,
  output logic       oled_rst_n_o,
  output logic       oled_dc_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o
);

  localparam int T_MAX_A   = (T_VDD_CYC > T_RST_CYC) ? T_VDD_CYC : T_RST_CYC;
  localparam int T_MAX_B   = (T_MAX_A > T_VBAT_CYC) ? T_MAX_A : T_VBAT_CYC;
  localparam int SHIFT_CYC = 16 * CLK_DIV;
  localparam int CNT_MAX   = (T_MAX_B > SHIFT_CYC) ? T_MAX_B : SHIFT_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] VDD_LAST  = CNT_W'(T_VDD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] VBAT_LAST = CNT_W'(T_VBAT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_OFF       = 4'd0,
    S_VDD_WAIT  = 4'd1,
    S_RST       = 4'd2,
    S_VBAT_WAIT = 4'd3,
    S_LOAD      = 4'd4,
    S_IDLE      = 4'd5,
    S_SHIFT     = 4'd6,
    S_RECOVER   = 4'd7,
    S_PWR_DOWN  = 4'd8
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [6:0]       shreg_r, shreg_s;   // bits still to send after the one on mosi
  logic             vdd_n_r, vdd_n_s;
  logic             vbat_n_r, vbat_n_s;
  logic             rst_n_r, rst_n_s;
  logic             dc_r, dc_s;
  logic             sck_r, sck_s;
  logic             mosi_r, mosi_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             pwr_on_r, pwr_on_s;

`ifdef OLED_SPI_CTRL_INIT_ROM_EN
  logic [2:0] rom_idx_r, rom_idx_s;
  logic       rom_mode_r, rom_mode_s;
  logic [7:0] rom_byte_s;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'hAE;
      3'd1:    init_byte = 8'h8D;
      3'd2:    init_byte = 8'h14;
      3'd3:    init_byte = 8'hD9;
      3'd4:    init_byte = 8'hF1;
      3'd5:    init_byte = 8'hAF;
      default: init_byte = 8'hAF;
    endcase
  endfunction
`endif

  // Next-state, counters and next registered output values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    dc_s    = dc_r;
    sck_s   = sck_r;
    mosi_s  = mosi_r;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
    rom_idx_s  = rom_idx_r;
    rom_mode_s = rom_mode_r;
    rom_byte_s = init_byte(rom_idx_r);
`endif
    case (state_r)
      S_OFF: begin
        if (start_i) begin
          state_s = S_VDD_WAIT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_OFF;
        end
      end
      S_VDD_WAIT: begin
        if (cnt_r == VDD_LAST) begin
          state_s = S_RST;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RST: begin
        if (cnt_r == RST_LAST) begin
          state_s = S_VBAT_WAIT;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_VBAT_WAIT: begin
        if (cnt_r == VBAT_LAST) begin
          cnt_s = CNT_ZERO;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
          state_s    = S_LOAD;
          rom_idx_s  = 3'd0;
          rom_mode_s = 1'b1;
`else
          state_s = S_IDLE;
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
      S_LOAD: begin
        state_s = S_SHIFT;
        shreg_s = rom_byte_s[6:0];
        mosi_s  = rom_byte_s[7];
        dc_s    = 1'b0;
        sck_s   = 1'b0;
        cnt_s   = CNT_ZERO;
        bit_s   = 3'd0;
      end
`endif
      S_IDLE: begin
        // A pending byte wins over a shutdown request in the same cycle
        if (valid_i) begin
          state_s = S_SHIFT;
          shreg_s = data_i[6:0];
          mosi_s  = data_i[7];
          dc_s    = dc_i;
          sck_s   = 1'b0;
          cnt_s   = CNT_ZERO;
          bit_s   = 3'd0;
        end else if (shutdown_i) begin
          state_s = S_PWR_DOWN;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s = CNT_ZERO;
          if (!sck_r) begin
            sck_s = 1'b1;
          end else begin
            sck_s = 1'b0;
            if (bit_r == 3'd7) begin
              state_s = S_RECOVER;
              mosi_s  = 1'b0;
            end else begin
              bit_s   = bit_r + 3'd1;
              mosi_s  = shreg_r[6];
              shreg_s = {shreg_r[5:0], 1'b0};
            end
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RECOVER: begin
        sck_s  = 1'b0;
        mosi_s = 1'b0;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
        if (rom_mode_r && (rom_idx_r != 3'd5)) begin
          state_s   = S_LOAD;
          rom_idx_s = rom_idx_r + 3'd1;
        end else begin
          state_s    = S_IDLE;
          rom_mode_s = 1'b0;
        end
`else
        state_s = S_IDLE;
`endif
      end
      S_PWR_DOWN: begin
        if (cnt_r == VBAT_LAST) begin
          state_s = S_OFF;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = S_OFF;
        cnt_s   = CNT_ZERO;
        sck_s   = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase

    // Pad and handshake levels follow the state being entered
    vdd_n_s  = (state_s == S_OFF);
    vbat_n_s = (state_s == S_OFF) || (state_s == S_VDD_WAIT) ||
               (state_s == S_RST) || (state_s == S_PWR_DOWN);
    rst_n_s  = (state_s != S_RST);
    ready_s  = (state_s == S_IDLE);
    busy_s   = (state_s != S_OFF) && (state_s != S_IDLE);
    pwr_on_s = (state_s == S_IDLE) || (state_s == S_SHIFT) ||
               (state_s == S_RECOVER) || (state_s == S_LOAD);
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= S_OFF;
      cnt_r    <= CNT_ZERO;
      bit_r    <= 3'd0;
      shreg_r  <= 7'd0;
      vdd_n_r  <= 1'b1;
      vbat_n_r <= 1'b1;
      rst_n_r  <= 1'b1;
      dc_r     <= 1'b0;
      sck_r    <= 1'b0;
      mosi_r   <= 1'b0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      pwr_on_r <= 1'b0;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
      rom_idx_r  <= 3'd0;
      rom_mode_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      shreg_r  <= shreg_s;
      vdd_n_r  <= vdd_n_s;
      vbat_n_r <= vbat_n_s;
      rst_n_r  <= rst_n_s;
      dc_r     <= dc_s;
      sck_r    <= sck_s;
      mosi_r   <= mosi_s;
      ready_r  <= ready_s;
      busy_r   <= busy_s;
      pwr_on_r <= pwr_on_s;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
      rom_idx_r  <= rom_idx_s;
      rom_mode_r <= rom_mode_s;
`endif
    end
  end

  assign ready_o       = ready_r;
  assign busy_o        = busy_r;
  assign pwr_on_o      = pwr_on_r;
  assign oled_vdd_n_o  = vdd_n_r;
  assign oled_vbat_n_o = vbat_n_r;
  assign oled_rst_n_o  = rst_n_r;
  assign oled_dc_o     = dc_r;
  assign spi_sck_o     = sck_r;
  assign spi_mosi_o    = mosi_r;

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Self-checking bench for oled_spi_ctrl: power sequencing, SPI byte timing,
// shutdown deferral and asynchronous reset, against an arithmetic timing model.
`timescale 1ns/1ps
module tb_oled_spi_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int T_VDD     = 8;
  localparam int T_RST     = 3;
  localparam int T_VBAT    = 8;
  localparam int SHIFT_CYC = 16 * CLK_DIV;
  localparam int RDY_LOW   = SHIFT_CYC + 1;
  localparam int BYTE_GAP  = SHIFT_CYC + 2;
`ifdef OLED_SPI_CTRL_INIT_ROM_EN
  localparam int N_INIT = 6;
`else
  localparam int N_INIT = 0;
`endif
  localparam int T_READY = T_VDD + T_RST + T_VBAT + N_INIT * BYTE_GAP;
  localparam logic [8:0] RST_OUTS = 9'b111_000_000;

  logic       clk, rst;
  logic       start_i, shutdown_i, dc_i, valid_i;
  logic [7:0] data_i;
  logic       ready_o, busy_o, pwr_on_o;
  logic       oled_vdd_n_o, oled_vbat_n_o, oled_rst_n_o, oled_dc_o;
  logic       spi_sck_o, spi_mosi_o;
  logic [8:0] outs;

  assign outs = {oled_vdd_n_o, oled_vbat_n_o, oled_rst_n_o, oled_dc_o,
                 spi_sck_o, spi_mosi_o, ready_o, busy_o, pwr_on_o};

  oled_spi_ctrl #(
    .CLK_DIV(CLK_DIV), .T_VDD_CYC(T_VDD), .T_RST_CYC(T_RST), .T_VBAT_CYC(T_VBAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .shutdown_i(shutdown_i),
    .data_i(data_i), .dc_i(dc_i), .valid_i(valid_i), .ready_o(ready_o),
    .busy_o(busy_o), .pwr_on_o(pwr_on_o), .oled_vdd_n_o(oled_vdd_n_o),
    .oled_vbat_n_o(oled_vbat_n_o), .oled_rst_n_o(oled_rst_n_o),
    .oled_dc_o(oled_dc_o), .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1000;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_rx;
    logic       exp_dc;
    int         gap;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] init_exp[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Power-up from OFF; optional one-cycle shutdown pulse at sample sd_at.
  task automatic power_up(input string tag, input int sd_at);
    int rst_first, rst_len, rdy_at, vbat_at, bad_vdd, bad_dc, rx_n;
    logic [7:0] rx_sh;
    logic [7:0] rxq[$];
    logic prev_sck;
    rst_first = -1; rst_len = 0; rdy_at = -1; vbat_at = -1;
    bad_vdd = 0; bad_dc = 0; rx_n = 0; rx_sh = 8'h00; prev_sck = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check({tag, "_vdd_on"}, oled_vdd_n_o, 0);
    for (int j = 1; j <= T_READY + 20 && rdy_at < 0; j++) begin
      if (j == sd_at) shutdown_i = 1'b1;
      else if (j == sd_at + 1) shutdown_i = 1'b0;
      step();
      if (!oled_rst_n_o) begin
        if (rst_first < 0) rst_first = j;
        rst_len++;
      end
      if (!oled_vbat_n_o && vbat_at < 0) vbat_at = j;
      if (oled_vdd_n_o) bad_vdd++;
      if (ready_o) rdy_at = j;
      if (spi_sck_o && !prev_sck) begin
        rx_sh = {rx_sh[6:0], spi_mosi_o};
        rx_n++;
        if (oled_dc_o) bad_dc++;
        if (rx_n == 8) begin
          rxq.push_back(rx_sh);
          rx_n = 0;
        end
      end
      prev_sck = spi_sck_o;
    end
    check({tag, "_rst_start"}, rst_first, T_VDD);
    check({tag, "_rst_len"}, rst_len, T_RST);
    check({tag, "_vbat_on"}, vbat_at, T_VDD + T_RST);
    check({tag, "_vdd_held"}, bad_vdd, 0);
    check({tag, "_ready_at"}, rdy_at, T_READY);
    check({tag, "_pwr_on"}, pwr_on_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_init_count"}, rxq.size(), N_INIT);
    check({tag, "_init_dc"}, bad_dc, 0);
    for (int i = 0; i < rxq.size() && i < 6; i++)
      check({tag, "_init_byte"}, rxq[i], init_exp[i]);
  endtask

  // Send one byte and check every cycle of it against the timing model.
  task automatic xfer(input string tag, input logic [7:0] d, input logic dcb,
                      input logic [7:0] exp_rx, input logic exp_dc, input logic chk_gap);
    int t, acc, rises, rdy_low, bad_sck, bad_mosi, bad_rdy, bad_dc, bad_stable;
    logic [7:0] rx;
    logic prev_sck, prev_mosi, e_sck, e_mosi, e_rdy;
    data_i = d; dc_i = dcb; valid_i = 1'b1;
    t = 0;
    while (!ready_o && t < 200) begin
      step();
      t++;
    end
    check({tag, "_accept"}, ready_o, 1);
    if (!ready_o) begin
      valid_i = 1'b0;
      return;
    end
    step();
    acc = cyc;
    valid_i = 1'b0;
    data_i = 8'($urandom);
    dc_i = 1'($urandom);
    if (chk_gap) check({tag, "_gap"}, acc - last_acc, BYTE_GAP);
    last_acc = acc;
    rises = 0; rdy_low = 0; bad_sck = 0; bad_mosi = 0; bad_rdy = 0;
    bad_dc = 0; bad_stable = 0; rx = 8'h00; prev_sck = 1'b0; prev_mosi = spi_mosi_o;
    for (int j = 0; j <= SHIFT_CYC + 1; j++) begin
      if (j > 0) step();
      e_sck  = (j < SHIFT_CYC) ? 1'((j / CLK_DIV) % 2) : 1'b0;
      e_mosi = (j < SHIFT_CYC) ? d[7 - j / (2 * CLK_DIV)] : 1'b0;
      e_rdy  = (j == SHIFT_CYC + 1);
      if (spi_sck_o !== e_sck) bad_sck++;
      if (spi_mosi_o !== e_mosi) bad_mosi++;
      if (ready_o !== e_rdy || busy_o !== !e_rdy) bad_rdy++;
      if (oled_dc_o !== exp_dc) bad_dc++;
      if (!ready_o) rdy_low++;
      if (j > 0 && spi_mosi_o !== prev_mosi && !(prev_sck && !spi_sck_o)) bad_stable++;
      if (spi_sck_o && !prev_sck) begin
        rx = {rx[6:0], spi_mosi_o};
        rises++;
      end
      prev_sck = spi_sck_o;
      prev_mosi = spi_mosi_o;
    end
    check({tag, "_sck"}, bad_sck, 0);
    check({tag, "_mosi"}, bad_mosi, 0);
    check({tag, "_mosi_stable"}, bad_stable, 0);
    check({tag, "_ready_busy"}, bad_rdy, 0);
    check({tag, "_ready_low"}, rdy_low, RDY_LOW);
    check({tag, "_dc"}, bad_dc, 0);
    check({tag, "_rises"}, rises, 8);
    check({tag, "_rx"}, rx, exp_rx);
  endtask

  // Expect the next edge to start power-down and VDD to follow T_VBAT later.
  task automatic pwr_down_check(input string tag, input logic exp_dc);
    int n;
    step();
    check({tag, "_vbat_off"}, oled_vbat_n_o, 1);
    check({tag, "_vdd_still_on"}, oled_vdd_n_o, 0);
    check({tag, "_busy_pd"}, busy_o, 1);
    n = 0;
    while (!oled_vdd_n_o && n < 50) begin
      step();
      n++;
    end
    check({tag, "_vdd_delay"}, n, T_VBAT);
    check({tag, "_off_outs"}, outs, {3'b111, exp_dc, 5'b00000});
  endtask

  int t, rises, gap;
  logic prev;
  logic [7:0] rd;
  logic rdc;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1};
    tbl[1] = '{8'h00, 1'b0, 8'h00, 1'b0, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    tbl[3] = '{8'h80, 1'b0, 8'h80, 1'b0, 2};
    tbl[4] = '{8'h01, 1'b1, 8'h01, 1'b1, 0};
    tbl[5] = '{8'h5A, 1'b0, 8'h5A, 1'b0, 3};
    init_exp = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hAF};

    rst = 1'b1; start_i = 1'b0; shutdown_i = 1'b0;
    dc_i = 1'b0; valid_i = 1'b0; data_i = 8'h00;
    repeat (3) step();
    check("reset_outs", outs, RST_OUTS);
    rst = 1'b0;
    step();
    step();
    check("off_hold", outs, RST_OUTS);

    // Power-up with a shutdown pulse during VDD_WAIT that must be forgotten
    power_up("pu1", 2);
    repeat (3) step();
    check("sd_pulse_ignored", ready_o, 1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("start_in_idle", outs, 9'b001_0_00_101);

    for (int i = 0; i < 6; i++) begin
      repeat (tbl[i].gap) step();
      xfer($sformatf("vec%0d", i), tbl[i].data, tbl[i].dc, tbl[i].exp_rx,
           tbl[i].exp_dc, (i > 0) && (tbl[i].gap == 0));
    end

    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 3);
      rd = 8'($urandom_range(0, 255));
      rdc = 1'($urandom_range(0, 1));
      repeat (gap) step();
      xfer($sformatf("rnd%0d", i), rd, rdc, rd, rdc, gap == 0);
    end

    // valid_i and shutdown_i together: byte first, then power-down
    shutdown_i = 1'b1;
    xfer("sd_byte", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
    pwr_down_check("sd1", 1'b1);
    check("sd1_busy", busy_o, 0);
    shutdown_i = 1'b0;

    // shutdown held through power-up acts only once IDLE is reached
    shutdown_i = 1'b1;
    power_up("pu2", -1);
    pwr_down_check("sd2", (N_INIT > 0) ? 1'b0 : 1'b1);
    shutdown_i = 1'b0;

    // Asynchronous reset in the middle of a byte
    power_up("pu3", -1);
    data_i = 8'hC3; dc_i = 1'b1; valid_i = 1'b1;
    t = 0;
    while (!ready_o && t < 100) begin
      step();
      t++;
    end
    check("arst_accept", ready_o, 1);
    step();
    valid_i = 1'b0;
    rises = 0; prev = 1'b0; t = 0;
    while (rises < 3 && t < 200) begin
      step();
      t++;
      if (spi_sck_o && !prev) rises++;
      prev = spi_sck_o;
    end
    check("arst_rises", rises, 3);
    #2 rst = 1'b1;
    #1 check("arst_immediate", outs, RST_OUTS);
    step();
    check("arst_held", outs, RST_OUTS);
    rst = 1'b0;
    step();
    check("arst_off", outs, RST_OUTS);
    power_up("pu4", -1);
    xfer("post_rst", 8'h96, 1'b0, 8'h96, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
